load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Data-side master for the shared 64x32 unified memory. It sits between the execute stage and the memory's data ports.
- Accepts one load/store request at a time via a valid/ready handshake and performs byte, halfword or word accesses.
- Sub-word stores are done as read-modify-write, because the memory writes whole words only.
- Loads are sign- or zero-extended. Misaligned, illegal-size and out-of-range requests are reported as errors and never touch memory.

Parameters:
- ADDR_LIMIT, 256: byte-address bound; any address >= ADDR_LIMIT is out of range.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  request rejected (valid with resp_valid)
- mem_raddr  out  32  to memory load-address port
- mem_rdata  in  32  from memory load-data output (combinational)
- mem_we  out  1  memory write enable
- mem_waddr  out  32  to memory store-address port
- mem_wdata  out  32  to memory store-data port

Behaviour:
- Reset and clock: rst is asynchronous and active-high; clk is the clock.
- Reset values:
  - state IDLE, so req_ready=1
  - resp_valid=0, resp_rdata=0, resp_err=0
  - mem_we=0
  - latched address and data = 0, so mem_raddr=mem_waddr=mem_wdata=0
- Outputs derived from state: req_ready = (state==IDLE); resp_valid = (state==RESP); mem_we = (state==WRITE).
- Handshake:
  - A request is accepted at a rising edge with req_valid && req_ready. All req_* fields are latched at that edge.
  - req_* are ignored outside IDLE.
  - No response backpressure: resp_valid is high for exactly one cycle.
- FSM, per accepted request:
  - Error (size==11; half with addr[0]!=0; word with addr[1:0]!=0; addr>=ADDR_LIMIT): IDLE->RESP, err=1, rdata=0. mem_we is never asserted.
  - Load: IDLE->READ->RESP.
    - In READ, mem_raddr = {addr[31:2],2'b00}.
    - mem_rdata is captured at the edge leaving READ.
  - Word store: IDLE->WRITE->RESP.
    - mem_waddr = aligned address; mem_wdata = wdata.
  - Byte/half store: IDLE->READ->WRITE->RESP.
    - The old word is captured at the end of READ.
    - In WRITE, mem_wdata = old word with the selected lane replaced.
  - RESP->IDLE unconditionally. A new request can be accepted on the edge after RESP.
- Lanes are little-endian:
  - byte n = addr[1:0] occupies bits [8n+7:8n]
  - half h = addr[1] occupies bits [16h+15:16h]
- Load extension: the selected lane is shifted to bit 0. Sign-extend from bit 7/15 if req_signed, else zero-fill. Word loads ignore req_signed.
- Store data: only req_wdata[7:0] (byte) or [15:0] (half) is used; upper bits are ignored.
- mem_we is high for exactly one cycle per store, and never for loads or errors.
- mem_waddr/mem_wdata/mem_raddr hold their last values outside their active states. They are stable throughout WRITE.
- Reset mid-operation: the FSM returns to IDLE immediately.
  - No write is issued after reset deasserts.
  - No stale resp_valid is produced.
- Cycles from accept edge to the cycle in which resp_valid is high:
  - error: 1
  - load: 2
  - word store: 2
  - sub-word store: 3

Test Plan:
1. Reset, then word store 0x8899AABB to 0x10.
   - Expect mem_we high for one cycle with mem_waddr=0x10.
   - resp_valid 2 cycles after accept, err=0, rdata=0.
   - A word load of 0x10 then returns 0x8899AABB.
2. Byte loads of 0x11.
   - signed -> 0xFFFFFFAA
   - unsigned -> 0x000000AA
   - half load of 0x12, signed -> 0xFFFF8899
   - No mem_we pulses during any of these loads.
3. Byte store 0x1234565C to 0x13.
   - Sequence READ, WRITE, RESP.
   - mem_wdata=0x5C99AABB.
   - A word load of 0x10 then returns 0x5C99AABB.
4. Error requests:
   - word load of 0x0E, half store to 0x11, size=11 load of 0x10, word load of 0x100.
   - Each gives resp_err=1, rdata=0, one cycle after accept, with no mem_we.
5. Assert rst during READ of a half store to 0x12.
   - mem_we stays 0.
   - req_ready=1 and resp_valid=0 after release.
   - The next request completes normally.
6. Hold req_valid high with two back-to-back loads.
   - req_ready low from accept through RESP.
   - The second request is accepted on the edge after RESP.
   - Each request gets exactly one resp_valid pulse.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake and data-memory port bundle of the load/store unit.
interface load_store_unit_if;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic        mem_we;
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_raddr, mem_we, mem_waddr, mem_wdata
  );
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_raddr, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: data-side memory master doing byte/half/word loads and read-modify-write sub-word stores.
module load_store_unit #(
  parameter int unsigned ADDR_LIMIT = 256
) (
  input logic clk,
  input logic rst,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state, nxt;
  logic we_q, sgn_q, err_q, bad;
  logic [1:0] size_q, off_q;
  logic [31:0] wdata_q, rdata_q, raddr_q, waddr_q, mdata_q, ld, mask, merged;
  logic [4:0] sh;
  logic [15:0] lane;
  assign bad = bus.req_size == 2'b11 || (bus.req_size == 2'b01 && bus.req_addr[0]) ||
               (bus.req_size == 2'b10 && |bus.req_addr[1:0]) || bus.req_addr >= ADDR_LIMIT;
  assign sh = {off_q, 3'b000};
  assign lane = 16'(bus.mem_rdata >> sh);
  assign ld = size_q == 2'b00 ? {{24{sgn_q & lane[7]}}, lane[7:0]} :
              size_q == 2'b01 ? {{16{sgn_q & lane[15]}}, lane} : bus.mem_rdata;
  assign mask = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
  assign merged = (bus.mem_rdata & ~mask) | ((wdata_q << sh) & mask);
  assign bus.req_ready = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign bus.mem_we = state == WRITE;
  assign bus.mem_raddr = raddr_q;
  assign bus.mem_waddr = waddr_q;
  assign bus.mem_wdata = mdata_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err = err_q;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !bus.req_valid ? IDLE : bad ? RESP :
                     (bus.req_we && bus.req_size == 2'b10) ? WRITE : READ;
      READ:    nxt = we_q ? WRITE : RESP;
      WRITE:   nxt = RESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      we_q <= 1'b0;
      sgn_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= 2'b00;
      off_q <= 2'b00;
      wdata_q <= '0;
      rdata_q <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      mdata_q <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.req_valid) begin
        we_q <= bus.req_we;
        sgn_q <= bus.req_signed;
        size_q <= bus.req_size;
        off_q <= bus.req_addr[1:0];
        wdata_q <= bus.req_wdata;
        err_q <= bad;
        rdata_q <= '0;
        if (nxt == READ) raddr_q <= {bus.req_addr[31:2], 2'b00};
        if (nxt == WRITE) begin
          waddr_q <= {bus.req_addr[31:2], 2'b00};
          mdata_q <= bus.req_wdata;
        end
      end
      // Leaving READ: loads capture the extended lane, sub-word stores capture the merged word.
      if (state == READ) begin
        if (we_q) begin
          waddr_q <= raddr_q;
          mdata_q <= merged;
        end else rdata_q <= ld;
      end
    end
  end
endmodule
